// File: rtl/instr_prefetch_queue_if.sv
// Fetch-side bundle: the instruction-memory handshake and the IF/ID valid/ready port.
// The prefetch queue uses the master modport; memory and the pipeline sit on the slave side.
interface instr_prefetch_queue_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcn;

    modport master (
        output mem_req, mem_addr, instr_valid, instr, pc, pcn,
        input  mem_gnt, mem_rvalid, mem_rdata, instr_ready
    );

    modport slave (
        input  mem_req, mem_addr, instr_valid, instr, pc, pcn,
        output mem_gnt, mem_rvalid, mem_rdata, instr_ready
    );
endinterface

// File: rtl/instr_prefetch_queue.sv
// Sequential instruction prefetcher with a small FIFO ahead of IF/ID; redirects flush everything.
// Define PFQ_BYPASS_EN to forward a response straight to IF/ID when the FIFO is empty.
module instr_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    instr_prefetch_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DISCARD} state_t;

    state_t         state;
    logic [31:0]    fetch_pc;
    logic [31:0]    req_pc;
    logic [31:0]    instr_q [DEPTH];
    logic [31:0]    pc_q    [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_after;
    logic           head_valid;
    logic           bypass;
    logic           push;
    logic           pop;
    logic [31:0]    head_pc;

    always_comb begin
        head_valid = (count != '0);
`ifdef PFQ_BYPASS_EN
        bypass = !head_valid && (state == WAIT) && bus.mem_rvalid && bus.instr_ready && !redirect_i;
`else
        bypass = 1'b0;
`endif
        push        = (state == WAIT) && bus.mem_rvalid && !redirect_i && !bypass;
        pop         = head_valid && bus.instr_ready && !redirect_i;
        count_after = count + CW'(push) - CW'(pop);
    end

    assign head_pc          = bypass ? req_pc : pc_q[rd_ptr];
    assign bus.mem_req      = (state == REQ);
    assign bus.mem_addr     = fetch_pc;
    assign bus.instr_valid  = (head_valid | bypass) & ~redirect_i;
    assign bus.instr        = bypass ? bus.mem_rdata : instr_q[rd_ptr];
    assign bus.pc           = head_pc;
    assign bus.pcn          = head_pc + 32'd4;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else if (redirect_i) begin
            fetch_pc <= redirect_pc_i & ~32'h3;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            // A request already granted must still have its response swallowed.
            unique case (state)
                REQ:     state <= bus.mem_gnt    ? DISCARD : REQ;
                WAIT:    state <= bus.mem_rvalid ? REQ     : DISCARD;
                DISCARD: state <= bus.mem_rvalid ? REQ     : DISCARD;
                default: state <= REQ;
            endcase
        end else begin
            if (push) begin
                instr_q[wr_ptr] <= bus.mem_rdata;
                pc_q[wr_ptr]    <= req_pc;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count_after;
            unique case (state)
                IDLE: if (count < FULL) state <= REQ;
                REQ: if (bus.mem_gnt) begin
                    state    <= WAIT;
                    req_pc   <= fetch_pc;
                    fetch_pc <= fetch_pc + 32'd4;
                end
                WAIT:    if (bus.mem_rvalid) state <= (count_after < FULL) ? REQ : IDLE;
                DISCARD: if (bus.mem_rvalid) state <= REQ;
                default: state <= IDLE;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n)
        !(push && !pop && count == FULL));

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Randomized bench: memory responder plus an in-order address-stream model of the pipeline output.
// Expected instructions are a fixed function of their address, so stale or lost fetches show up.
module tb_instr_prefetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef PFQ_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;

    instr_prefetch_queue_if bus ();

    instr_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk_i         (clk),
        .rst_n         (rst_n),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Memory and pipeline environment state
    bit          outstanding = 0;
    logic [31:0] out_addr = '0;
    int          delay = 0;
    bit          drv_gnt = 0;
    bit          drv_rvalid = 0;
    logic [31:0] gnt_addr = '0;
    int          gnt_pct = 100;
    int          ready_pct = 100;
    int          lat_min = 0;
    int          lat_max = 0;
    int          redir_mode = 0;      // 0 none, 1 random, 2 wait-no-rvalid, 3 on gnt, 4 now
    logic [31:0] redir_target = '0;
    bit          redir_fired = 0;
    int          cyc = 0;
    int          pops = 0;
    int          gnts = 0;
    int          first_rv_cyc = -1;
    int          first_val_cyc = -1;

    // Reference model: next expected IF/ID pc and next expected fetch address
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] exp_gnt = RESET_PC;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        bit rv;
        bit rd;
        bit rdy;
        logic [31:0] rpc;
        @(negedge clk);
        cyc++;
        if (drv_rvalid) outstanding = 0;
        if (drv_gnt) begin
            outstanding = 1;
            out_addr    = gnt_addr;
            delay       = $urandom_range(lat_max, lat_min);
        end
        drv_gnt  = bus.mem_req && ($urandom_range(99, 0) < gnt_pct);
        gnt_addr = bus.mem_addr;
        rv = 0;
        if (outstanding) begin
            if (delay == 0) rv = 1;
            else delay--;
        end
        drv_rvalid = rv;
        rpc = redir_target;
        case (redir_mode)
            1: begin rd = ($urandom_range(99, 0) < 4); rpc = $urandom; end
            2: rd = outstanding && !rv;
            3: rd = drv_gnt;
            4: rd = 1;
            default: rd = 0;
        endcase
        if (rd && redir_mode > 1) begin
            redir_mode  = 0;
            redir_fired = 1;
        end
        rdy = ($urandom_range(99, 0) < ready_pct);
        redirect        = rd;
        redirect_pc     = rpc;
        bus.mem_gnt     = drv_gnt;
        bus.mem_rvalid  = rv;
        bus.mem_rdata   = rv ? mem_word(out_addr) : $urandom;
        bus.instr_ready = rdy;
        if (rv && first_rv_cyc < 0) first_rv_cyc = cyc;
        #1;
        if (drv_gnt) begin
            gnts++;
            chk("gnt_addr", gnt_addr, exp_gnt);
            chk("one_outstanding", 32'(outstanding), 32'd0);
            exp_gnt = exp_gnt + 32'd4;
        end
        if (rd) begin
            chk("valid_in_redirect", 32'(bus.instr_valid), 32'd0);
            exp_pc  = rpc & ~32'h3;
            exp_gnt = rpc & ~32'h3;
        end else if (bus.instr_valid && rdy) begin
            if (first_val_cyc < 0) first_val_cyc = cyc;
            chk("pop_pc", bus.pc, exp_pc);
            chk("pop_pcn", bus.pcn, exp_pc + 32'd4);
            chk("pop_instr", bus.instr, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            pops++;
        end
    endtask

    task automatic run_until_pops(input string tag, input int n, input int budget);
        int start = pops;
        for (int i = 0; i < budget && (pops - start) < n; i++) step();
        chk(tag, 32'((pops - start) >= n), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(bus.instr_valid), 32'd0);
        chk({tag, "_instr"}, bus.instr, 32'd0);
        chk({tag, "_pc"}, bus.pc, 32'd0);
        chk({tag, "_pcn"}, bus.pcn, 32'd4);
        chk({tag, "_req"}, 32'(bus.mem_req), 32'd0);
        chk({tag, "_addr"}, bus.mem_addr, RESET_PC);
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int g0;
        bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0; bus.instr_ready = 0;
        repeat (2) @(negedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1;

        // Back-to-back fetch with immediate grant and single-cycle response
        gnt_pct = 100; ready_pct = 100; lat_min = 0; lat_max = 0;
        run_until_pops("basic_progress", 6, 60);
        chk("fetch_latency", 32'(first_val_cyc - first_rv_cyc), 32'(LAT));

        // Stall the pipeline: exactly DEPTH fetches fill the queue, then fetch stops
        ready_pct = 0; redir_mode = 4; redir_target = 32'h0;
        step();
        g0 = gnts;
        run_cycles(40);
        chk("full_grants", 32'(gnts - g0), 32'(DEPTH));
        chk("full_req_idle", 32'(bus.mem_req), 32'd0);
        ready_pct = 100;
        run_until_pops("drain_progress", 6, 60);

        // Redirect while waiting for data, no response in that cycle
        lat_min = 1; lat_max = 2; redir_fired = 0; redir_mode = 2; redir_target = 32'h100;
        run_cycles(10);
        chk("redir_wait_fired", 32'(redir_fired), 32'd1);
        run_until_pops("redir_wait_progress", 4, 80);

        // Redirect on the grant, then a second redirect before the stale response
        redir_fired = 0; redir_mode = 3; redir_target = 32'h180;
        run_cycles(10);
        chk("redir_gnt_fired", 32'(redir_fired), 32'd1);
        redir_fired = 0; redir_mode = 2; redir_target = 32'h200;
        step();
        chk("redir_discard_fired", 32'(redir_fired), 32'd1);
        run_until_pops("redir_discard_progress", 4, 80);

        // Address wrap, with an unaligned redirect target
        lat_min = 0; lat_max = 1; redir_mode = 4; redir_target = 32'hFFFF_FFFE;
        step();
        run_until_pops("wrap_progress", 3, 60);

        // Full-queue push/pop overlap and random traffic with random redirects
        gnt_pct = 70; ready_pct = 60; lat_min = 0; lat_max = 3; redir_mode = 1;
        run_until_pops("random_progress", 200, 4000);
        redir_mode = 0;

        // Reset with a request outstanding
        for (int i = 0; i < 40 && !outstanding; i++) step();
        chk("reset_mid_outstanding", 32'(outstanding), 32'd1);
        #1 rst_n = 0;
        #1 check_reset_outputs("midreset");
        redirect = 0; bus.mem_gnt = 0; bus.mem_rvalid = 0;
        outstanding = 0; drv_gnt = 0; drv_rvalid = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        bus.mem_rvalid = 1; bus.mem_rdata = 32'hBAD0_BAD0;
        drv_rvalid = 1;
        exp_pc = RESET_PC; exp_gnt = RESET_PC;
        gnt_pct = 100; ready_pct = 100; lat_min = 0; lat_max = 1;
        run_until_pops("post_reset_progress", 4, 60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
